// File: rtl/cgra_imem_loader.sv
// cgra_imem_loader: parses a 32-bit header/data load stream and drives one-hot IM write strobes.
// Rev 1.0 - initial release.
`default_nettype none

module cgra_imem_loader #(
  parameter int NUM_ID            = 10,
  parameter int NUM_IMM           = 3,
  parameter int I_WIDTH           = 12,
  parameter int I_IMM_WIDTH       = 33,
  parameter int IM_MEM_ADDR_WIDTH = 8,
  parameter int LOAD_WIDTH        = 32
) (
  input  logic                            iClk,
  input  logic                            iReset,
  input  logic                            iLoad_Valid,
  output logic                            oLoad_Ready,
  input  logic [LOAD_WIDTH-1:0]           iLoad_Data,
  input  logic                            iHold,
  input  logic                            iStart,
  output logic [NUM_ID+NUM_IMM-1:0]       oIM_WriteEnable,
  output logic [IM_MEM_ADDR_WIDTH-1:0]    oIM_WriteAddress,
  output logic [I_WIDTH-1:0]              oIM_WriteData,
  output logic [I_IMM_WIDTH-1:0]          oIM_WriteData_IMM,
  output logic                            oBusy,
  output logic                            oDone,
  output logic                            oError
);

  localparam int NUM_T     = NUM_ID + NUM_IMM;
  localparam int IMM_BEATS = (I_IMM_WIDTH + 31) / 32;

  localparam logic [1:0] S_HEADER = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic [1:0]                   state, state_next;
  logic [7:0]                   hdr_target;
  logic [7:0]                   target;
  logic [IM_MEM_ADDR_WIDTH-1:0] addr;
  logic [11:0]                  remaining;
  logic [1:0]                   beat;
  logic [I_IMM_WIDTH-1:0]       acc, acc_next;
  logic                         accept, is_imm, last_beat, word_done;

  assign hdr_target = iLoad_Data[31:24];
  assign accept     = iLoad_Valid && oLoad_Ready;
  assign is_imm     = (target >= 8'(NUM_ID));
  assign last_beat  = !is_imm || (beat == 2'(IMM_BEATS - 1));
  assign word_done  = accept && (state == S_DATA) && last_beat;

  // Merge the current beat into its 32-bit chunk; bits past I_IMM_WIDTH are dropped.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < I_IMM_WIDTH; i++) begin
      acc_next[i] = ((i / 32) == int'(beat)) ? iLoad_Data[i % 32] : acc[i];
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) state <= S_HEADER;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_HEADER: begin
        if (accept) begin
          if (hdr_target < 8'(NUM_T))    state_next = S_DATA;
          else if (hdr_target == 8'hFF)  state_next = S_DONE;
          else                           state_next = S_ERROR;
        end
      end
      S_DATA:  if (word_done && (remaining == 12'd0)) state_next = S_HEADER;
      S_DONE:  if (iStart) state_next = S_HEADER;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_HEADER;
    endcase
  end

  always_comb begin
    oLoad_Ready = 1'b0;
    oBusy       = 1'b0;
    oDone       = 1'b0;
    oError      = 1'b0;
    case (state)
      S_HEADER: oLoad_Ready = !iHold;
      S_DATA: begin
        oLoad_Ready = !iHold;
        oBusy       = 1'b1;
      end
      S_DONE:  oDone  = 1'b1;
      S_ERROR: oError = 1'b1;
      default: oLoad_Ready = 1'b0;
    endcase
  end

  // Datapath: the strobe is a single-cycle pulse; address/data hold between strobes.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      target            <= '0;
      addr              <= '0;
      remaining         <= '0;
      beat              <= '0;
      acc               <= '0;
      oIM_WriteEnable   <= '0;
      oIM_WriteAddress  <= '0;
      oIM_WriteData     <= '0;
      oIM_WriteData_IMM <= '0;
    end else begin
      oIM_WriteEnable <= '0;
      if (accept && (state == S_HEADER)) begin
        target    <= hdr_target;
        addr      <= iLoad_Data[12 +: IM_MEM_ADDR_WIDTH];
        remaining <= iLoad_Data[11:0];
        beat      <= '0;
      end
      if (accept && (state == S_DATA)) begin
        if (last_beat) begin
          oIM_WriteEnable   <= NUM_T'(1) << target;
          oIM_WriteAddress  <= addr;
          oIM_WriteData     <= iLoad_Data[I_WIDTH-1:0];
          oIM_WriteData_IMM <= acc_next;
          addr              <= addr + IM_MEM_ADDR_WIDTH'(1);
          remaining         <= remaining - 12'd1;
          beat              <= '0;
        end else begin
          beat <= beat + 2'd1;
          acc  <= acc_next;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/cgra_imem_loader.md
Name: cgra_imem_loader

Overview:
- Streaming configuration loader that fills the CGRA's instruction memories (decoder IMs and immediate IMs) from a single 32-bit load stream.
- Generalises the fixed write port of the CGRA memory block: any number of IMs, immediate words wider than the bus (multi-beat), packetised bursts with auto-increment, end-of-program and error detection.
- Sits between the host/DMA configuration port and the IM write ports (WriteEnable/WriteAddress/WriteData/WriteData_IMM) of the CGRA memory block.

Parameters:
- NUM_ID, 10, number of decoder instruction memories (targets 0..NUM_ID-1)
- NUM_IMM, 3, number of immediate instruction memories (targets NUM_ID..NUM_ID+NUM_IMM-1)
- I_WIDTH, 12, decoder instruction width; must be ≤ LOAD_WIDTH
- I_IMM_WIDTH, 33, immediate instruction width; 1..4*LOAD_WIDTH
- IM_MEM_ADDR_WIDTH, 8, IM address width; must be ≤ 12
- LOAD_WIDTH, 32, load stream width; fixed at 32 (header format depends on it)

Ports:
- iClk  in  1  clock
- iReset  in  1  synchronous, active-high reset
- iLoad_Valid  in  1  load word valid
- oLoad_Ready  out  1  loader accepts word; a beat transfers when Valid&&Ready
- iLoad_Data  in  LOAD_WIDTH  header or data beat
- iHold  in  1  blocks acceptance (IM port in use by running CGRA)
- iStart  in  1  re-arm after DONE
- oIM_WriteEnable  out  NUM_ID+NUM_IMM  one-hot IM write strobe
- oIM_WriteAddress  out  IM_MEM_ADDR_WIDTH  shared write address
- oIM_WriteData  out  I_WIDTH  decoder instruction write data
- oIM_WriteData_IMM  out  I_IMM_WIDTH  immediate write data
- oBusy  out  1  high while inside a packet (DATA state)
- oDone  out  1  end-of-program marker received
- oError  out  1  sticky illegal-target flag

Behaviour:
- Reset: state HEADER; all outputs 0 except oLoad_Ready, which follows the HEADER rule. Reset mid-packet discards the partial word and performs no write.
- Header word fields:
  - [31:24] target
  - [23:12] start address (low IM_MEM_ADDR_WIDTH bits used)
  - [11:0] count_minus1 (1..4096 words)
- IMM_BEATS = ceil(I_IMM_WIDTH/32).
- States:
  - HEADER: Ready=!iHold. On accept:
    - target < NUM_ID+NUM_IMM -> latch target/address/count -> DATA.
    - target==8'hFF -> DONE.
    - Otherwise -> ERROR, oError=1.
  - DATA: Ready=!iHold.
    - Decoder target: each beat is one word = iLoad_Data[I_WIDTH-1:0].
    - Immediate target: IMM_BEATS beats per word, least-significant chunk first; the last beat supplies bits [I_IMM_WIDTH-1:32*(IMM_BEATS-1)] from its LSBs; unused upper bits are ignored.
    - After the final word: -> HEADER.
  - DONE: Ready=0, oDone=1. iStart -> HEADER with oDone cleared the next cycle.
  - ERROR: Ready=0 until iReset; iStart is ignored.
- Write timing:
  - Latency 1: the cycle after the last beat of a word is accepted, oIM_WriteEnable[target]=1 for exactly one cycle, with address and data valid in that same cycle.
  - Data/address outputs hold their last value when no strobe is active.
  - The unused data output (decoder vs immediate) is don't-care.
  - Back-to-back words produce strobes on consecutive cycles; there is no bubble.
- Address: increments by 1 per word, modulo 2^IM_MEM_ADDR_WIDTH (0xFF->0x00 at 8 bits). Counts larger than the IM depth simply wrap.
- iHold: when high, no beat is accepted and state/beat counters are frozen; a strobe already registered still completes. iHold can assert between beats of one immediate word.
- oBusy=1 exactly in DATA.
- iStart outside DONE is ignored.
- Valid low: nothing advances; gaps are allowed anywhere, including mid-word.

Test Plan:
- Decoder burst: 32'h03005002, then 0xABC, 0x123, 0x456 back-to-back -> WE bit3 for 3 consecutive cycles, addr 5/6/7, data 0xABC/0x123/0x456; oBusy falls after the last beat; back in HEADER.
- Immediate with wrap: 32'h0B0FF001, then beats 0xDEADBEEF, 0x1, 0x12345678, 0x0 -> WE bit11 at addr 0xFF data 33'h1DEADBEEF; then addr 0x00 data 33'h012345678; each strobe occurs one cycle after the second beat.
- Hold/gaps: the immediate packet above with iHold=1 for 3 cycles between beats and Valid toggling -> identical writes; oLoad_Ready=0 during hold; no extra strobes.
- End marker: 32'hFF000000 -> oDone=1, Ready=0; iStart pulse -> Ready=1, oDone=0; a following 32'h00000000 + 0x7 -> WE bit0, addr 0, data 0x7.
- Error: header target 0x0D (13) with 13 IMs -> oError=1, Ready=0; iStart is ignored; iReset -> oError=0, HEADER.
- Reset mid-packet: 32'h0B000000 + one beat, then iReset -> no strobe ever occurs; the next header is parsed correctly.
